// File: rtl/irq_controller_if.sv
// Trap-request bundle between peripherals/CSR controller and the interrupt controller.
// Pure wiring, no latency.
// No backpressure; stall is carried as an ordinary input.
interface irq_controller_if #(
  parameter int N_IRQ = 16
);
  logic [N_IRQ-1:0] irq_req_i;
  logic [31:0]      mie_i;
  logic             exception_i;
  logic             stall_i;
  logic             mret_i;
  logic             irq_o;
  logic [31:0]      irq_cause_o;
  logic [N_IRQ-1:0] irq_ret_o;

  // Controller side: consumes requests and core status, produces the trap strobe.
  modport slave (
    input  irq_req_i, mie_i, exception_i, stall_i, mret_i,
    output irq_o, irq_cause_o, irq_ret_o
  );

  // Core/peripheral side: drives requests and status, observes the trap.
  modport master (
    output irq_req_i, mie_i, exception_i, stall_i, mret_i,
    input  irq_o, irq_cause_o, irq_ret_o
  );
endinterface

// File: rtl/irq_controller.sv
// Fixed-priority interrupt arbiter issuing trap strobe/mcause and a one-cycle ack after MRET.
// Latency: request to irq_o is combinational (0 cycles) from IDLE; ack one cycle after MRET.
// Backpressure: stall_i defers the trap; handler occupancy holds off new requests until ACK.
module irq_controller #(
  parameter int N_IRQ = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  irq_controller_if.slave bus
);

  localparam int          IDX_W    = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [31:0] MIE_USED = ((32'd1 << N_IRQ) - 32'd1) << 16;

  typedef enum logic [1:0] {
    IDLE,
    IRQ_BUSY,
    EXC_BUSY,
    ACK
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_IRQ-1:0]   pending;
  logic [IDX_W-1:0]   win_idx;
  logic               irq_d;
  logic [31:0]        cause_d;
  logic [N_IRQ-1:0]   ret_d;
  logic               unused_mie;

  // mcause for line idx: interrupt bit plus local-interrupt code 16+idx.
  function automatic logic [31:0] cause_of(input logic [IDX_W-1:0] idx);
    return 32'h8000_0000 | (32'd16 + 32'(idx));
  endfunction

  // MIE bits outside the local-interrupt window have no meaning here.
  assign unused_mie = ^(bus.mie_i & ~MIE_USED);
  assign pending    = bus.irq_req_i & bus.mie_i[16 +: N_IRQ];

  // Fixed priority: scan high to low so the lowest pending index wins.
  always_comb begin
    win_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) win_idx = IDX_W'(i);
    end
  end

  // State and serviced-line register; reset drops any handler in flight without an ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state and outputs; exception wins over interrupts, outputs forced low in reset.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    irq_d   = 1'b0;
    cause_d = '0;
    ret_d   = '0;
    case (state_q)
      IDLE: begin
        if (bus.exception_i) begin
          state_d = EXC_BUSY;
        end else if (|pending && !bus.stall_i) begin
          irq_d   = 1'b1;
          cause_d = cause_of(win_idx);
          idx_d   = win_idx;
          state_d = IRQ_BUSY;
        end
      end
      IRQ_BUSY: begin
        cause_d = cause_of(idx_q);
        if (bus.mret_i) state_d = ACK;
      end
      ACK: begin
        cause_d = cause_of(idx_q);
        ret_d   = N_IRQ'(1) << idx_q;
        state_d = IDLE;
      end
      EXC_BUSY: begin
        if (bus.mret_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      irq_d   = 1'b0;
      cause_d = '0;
      ret_d   = '0;
    end
  end

  assign bus.irq_o       = irq_d;
  assign bus.irq_cause_o = cause_d;
  assign bus.irq_ret_o   = ret_d;

endmodule
